// File: rtl/load_scheduler_pkg.sv
// load_scheduler_pkg
//   Shared types and default sizing for the load scheduler and its FIFO.
//   - sched_state_t : scheduler FSM states
//   - SCHED_WIDTH   : default data width (count, terminal, load values)
//   - SCHED_DEPTH   : default FIFO depth (power of two, >= 2)
//   - SCHED_PTR_W   : FIFO pointer width for the default depth
package load_scheduler_pkg;

  localparam int SCHED_WIDTH = 4;
  localparam int SCHED_DEPTH = 4;
  localparam int SCHED_PTR_W = $clog2(SCHED_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/load_scheduler_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with registered occupancy. Head entry is presented
//   combinationally (show-ahead), so a pop consumes o_head in the same cycle.
//   Ports:
//     clk, reset       clock, async active-high reset
//     i_push, i_wdata  write request / data (ignored while full)
//     i_pop            read request (ignored while empty)
//     o_full, o_empty  status from the registered level
//     o_level          occupancy 0..DEPTH
//     o_head           entry at the read pointer
module sync_fifo
  import load_scheduler_pkg::*;
#(
  parameter int WIDTH = SCHED_WIDTH,
  parameter int DEPTH = SCHED_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic [WIDTH-1:0]           o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_head  = r_mem[r_rptr];

  // Full refuses a push even when a pop frees a slot in the same cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/load_scheduler.sv
// load_scheduler
//   Feeds a loadable counter a scripted sequence of reload values. Values
//   are queued in a FIFO; whenever count_i equals term_i and a value is
//   queued, the head is popped and presented as a one-cycle load pulse on
//   the following cycle. A terminal hit with nothing queued raises the
//   sticky miss_o flag.
//   Ports:
//     clk, reset              clock, async active-high reset
//     req_valid_i/req_val_i   reload value producer
//     req_ready_o             FIFO not full
//     count_i, term_i         counter value and terminal value
//     load_o, load_val_o      registered load pulse and value
//     level_o                 FIFO occupancy
//     miss_o, clr_miss_i      sticky underrun flag and its clear
module load_scheduler
  import load_scheduler_pkg::*;
#(
  parameter int WIDTH = SCHED_WIDTH,
  parameter int DEPTH = SCHED_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid_i,
  input  logic [WIDTH-1:0]       req_val_i,
  output logic                   req_ready_o,
  input  logic [WIDTH-1:0]       count_i,
  input  logic [WIDTH-1:0]       term_i,
  output logic                   load_o,
  output logic [WIDTH-1:0]       load_val_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   miss_o,
  input  logic                   clr_miss_i
);

  sched_state_t     r_state;
  logic             w_match;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_miss_set;
  logic [WIDTH-1:0] w_head;

  assign w_match = (count_i == term_i);
  assign w_push  = req_valid_i && !w_full;
  assign req_ready_o = !w_full;

  // IDLE implies an empty FIFO, so a match there is a miss; a match in FIRE
  // is deliberately dropped to avoid a double fire.
  assign w_pop      = (r_state == ARMED) && w_match;
  assign w_miss_set = (r_state == IDLE) && w_match;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (req_val_i),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level_o),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      load_o     <= 1'b0;
      load_val_o <= '0;
      miss_o     <= 1'b0;
    end else begin
      load_o <= 1'b0;

      // Set wins over clear.
      if (w_miss_set)      miss_o <= 1'b1;
      else if (clr_miss_i) miss_o <= 1'b0;

      case (r_state)
        IDLE: begin
          // A push this cycle makes the FIFO non-empty next cycle.
          if (!w_empty || w_push) r_state <= ARMED;
        end
        ARMED: begin
          if (w_match) begin
            load_o     <= 1'b1;
            load_val_o <= w_head;
            r_state    <= FIRE;
          end
        end
        FIRE: begin
          // Level here is already post-pop.
          if (!w_empty || w_push) r_state <= ARMED;
          else                    r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_scheduler.md
Name: load_scheduler

Overview:
- Upstream stage for the loadable 4-bit counter; drives that counter's load_i and load_val_i.
- Buffers queued reload values in a small FIFO.
- Watches the counter's count and issues a one-cycle load pulse with the next queued value each time the count reaches a programmable terminal value.
- Gives the counter a scripted sequence of wrap points instead of a free-running 0..15 wrap.

Parameters:
- WIDTH, 4, width of count, terminal and load values.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  producer presents a reload value.
- req_val_i  in  WIDTH  reload value.
- req_ready_o  out  1  FIFO can accept; high when not full.
- count_i  in  WIDTH  current counter value (the counter's count_o).
- term_i  in  WIDTH  terminal count; a match triggers a reload.
- load_o  out  1  one-cycle load pulse to the counter's load_i.
- load_val_o  out  WIDTH  value to load; valid while load_o is high.
- level_o  out  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- miss_o  out  1  sticky: terminal reached while the FIFO was empty.
- clr_miss_i  in  1  clears miss_o.

Behaviour:
- Reset (async assert, sync release):
  - FIFO is emptied and pointers go to 0.
  - State is IDLE.
  - load_o=0, load_val_o=0, level_o=0, miss_o=0, req_ready_o=1.
- Push:
  - Occurs on a clock edge where req_valid_i && req_ready_o.
  - The value is written at the write pointer and level increments.
  - req_ready_o = (level != DEPTH), derived combinationally from registered level.
  - When full, a push is refused even if a pop happens in the same cycle.
- Pop:
  - Occurs only on the transition into FIRE.
  - The head entry is registered into load_val_o and level decrements.
  - A push and a pop in the same cycle leave level unchanged.
- Pointers: WIDTH-free, clog2(DEPTH) bits, wrap modulo DEPTH.
- Match: (count_i == term_i), evaluated combinationally every cycle.
- State machine, all outputs registered:
  - IDLE: FIFO empty. On match, set miss_o and stay in IDLE. When level becomes nonzero, go to ARMED next cycle.
  - ARMED: FIFO non-empty. On match, pop the head and go to FIRE. load_o=1 and load_val_o=head in the cycle after the match, so latency from match cycle to load_o is 1.
  - FIRE: load_o high for exactly one cycle. A match during FIRE is ignored (no double fire, no miss). Next state is ARMED if the post-pop level is greater than 0, else IDLE.
- load_val_o holds its last value when load_o=0; only load_o is qualified.
- Push and match in the same cycle while IDLE: the pushed entry is not visible yet. No fire; miss_o is set. ARMED follows next cycle.
- miss_o and clr_miss_i:
  - clr_miss_i clears miss_o.
  - If clr_miss_i and a new miss occur in the same cycle, set wins.
- Arithmetic is unsigned; no saturation. Equality compare only.
- Reset mid-FIRE: load_o drops immediately (async) and queued entries are discarded.
- term_i may change at any time; it is sampled each cycle with no latching.

Decomposition:
- Shared package:
  - sched_state_t enum {IDLE, ARMED, FIRE}.
  - Localparam for pointer width, clog2(DEPTH).
- Natural sub-module: sync_fifo (WIDTH, DEPTH; push/pop/full/empty/level/head), reusable elsewhere.
- load_scheduler holds the FSM, the match compare and the miss flag.

Test Plan:
- Reset then push 4 values 3,7,1,9 with term_i=5 -> req_ready_o falls after the 4th push and level_o=4. A 5th push attempt is not accepted.
- FIFO holds 3, count_i ramps 0..6 with term_i=5 -> match at count 5 gives load_o=1 with load_val_o=3 for exactly one cycle on the next cycle. level_o goes 1->0 and the state returns to IDLE.
- Empty FIFO, count_i=5 with term_i=5 -> miss_o=1 and load_o stays 0. clr_miss_i pulse -> miss_o=0. clr_miss_i together with a new match -> miss_o stays 1.
- FIFO holds 2,8 and count_i is held at term_i for 3 cycles -> one pulse (value 2) in FIRE. The match during FIRE is ignored. The next match cycle after FIRE fires value 8 -> exactly two pulses, values in order 2 then 8.
- Full FIFO (DEPTH=4): push 6 with req_valid_i during a pop cycle -> not accepted. Level goes 4->3 and 6 is accepted the following cycle. Wrap check: push/pop 10 values 0..9 and confirm FIFO order.
- Assert reset while in FIRE with 2 entries queued -> load_o=0 immediately, level_o=0, miss_o=0. The first match after release sets miss_o (the FIFO is empty).
